// File: rtl/regfile_wb_sched.sv
// Write-port scheduler for a single-write-port Y86 register file.
// Serialises writeback E/M writes and debug writes onto one registered port.
module regfile_wb_sched #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [3:0]        icode_i,
  input  logic              cnd_i,
  input  logic [ADDR_W-1:0] dstE_i,
  input  logic [ADDR_W-1:0] dstM_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic [DATA_W-1:0] valM_i,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_data_i,
  output logic              dbg_gnt_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam logic [ADDR_W-1:0] NO_REG   = '1;
  localparam logic [3:0]        IC_RRMOV = 4'h2;

  typedef enum logic [1:0] {IDLE, WR_E, WR_M, WR_DBG} state_t;

  state_t              state_q, state_d;
  logic                last_wb_q, last_wb_d;   // 1: last grant went to writeback
  logic                need_m_q, need_m_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                we_d;
  logic [ADDR_W-1:0]   waddr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                done_d;
  logic [CNT_W-1:0]    retired_d;

  logic need_e_raw, need_m_raw, need_e;

  assign need_e_raw = (dstE_i != NO_REG) && ((icode_i != IC_RRMOV) || cnd_i);
  assign need_m_raw = (dstM_i != NO_REG);
  // Same destination on both ports: the memory value wins (popq %rsp).
  assign need_e     = need_e_raw && !(need_m_raw && (dstE_i == dstM_i));

  assign wb_ready_o = (state_q == IDLE) && !(dbg_req_i && last_wb_q);
  assign dbg_gnt_o  = (state_q == IDLE) && dbg_req_i && !(wb_valid_i && !last_wb_q);
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    last_wb_d = last_wb_q;
    need_m_d  = need_m_q;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    we_d      = 1'b0;
    waddr_d   = NO_REG;
    wdata_d   = '0;
    done_d    = 1'b0;
    retired_d = retired_o;

    unique case (state_q)
      IDLE: begin
        if (wb_valid_i && wb_ready_o) begin
          last_wb_d = 1'b1;
          need_m_d  = need_m_raw;
          m_addr_d  = dstM_i;
          m_data_d  = valM_i;
          if (need_e) begin
            state_d = WR_E;
            we_d    = 1'b1;
            waddr_d = dstE_i;
            wdata_d = valE_i;
            done_d  = !need_m_raw;
          end else if (need_m_raw) begin
            state_d = WR_M;
            we_d    = 1'b1;
            waddr_d = dstM_i;
            wdata_d = valM_i;
            done_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end else if (dbg_gnt_o) begin
          last_wb_d = 1'b0;
          state_d   = WR_DBG;
          we_d      = (dbg_addr_i != NO_REG);
          waddr_d   = dbg_addr_i;
          wdata_d   = dbg_data_i;
        end
      end
      WR_E: begin
        if (need_m_q) begin
          state_d = WR_M;
          we_d    = 1'b1;
          waddr_d = m_addr_q;
          wdata_d = m_data_q;
          done_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WR_M:    state_d = IDLE;
      WR_DBG:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (done_d) retired_d = retired_o + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      last_wb_q  <= 1'b0;
      need_m_q   <= 1'b0;
      m_addr_q   <= NO_REG;
      m_data_q   <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= NO_REG;
      rf_wdata_o <= '0;
      done_o     <= 1'b0;
      retired_o  <= '0;
    end else begin
      state_q    <= state_d;
      last_wb_q  <= last_wb_d;
      need_m_q   <= need_m_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
      rf_we_o    <= we_d;
      rf_waddr_o <= waddr_d;
      rf_wdata_o <= wdata_d;
      done_o     <= done_d;
      retired_o  <= retired_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed cases plus random traffic
// compared cycle by cycle against a transaction-queue reference model.
module tb_regfile_wb_sched;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wb_valid_i, wb_ready_o;
  logic [3:0]  icode_i;
  logic        cnd_i;
  logic [3:0]  dstE_i, dstM_i;
  logic [63:0] valE_i, valM_i;
  logic        dbg_req_i;
  logic [3:0]  dbg_addr_i;
  logic [63:0] dbg_data_i;
  logic        dbg_gnt_o, rf_we_o, busy_o, done_o;
  logic [3:0]  rf_waddr_o;
  logic [63:0] rf_wdata_o;
  logic [15:0] retired_o;

  regfile_wb_sched dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .icode_i(icode_i), .cnd_i(cnd_i),
    .dstE_i(dstE_i), .dstM_i(dstM_i), .valE_i(valE_i), .valM_i(valM_i),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_data_i(dbg_data_i),
    .dbg_gnt_o(dbg_gnt_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [63:0] data;
    logic        done;
    logic        busy;
  } cyc_t;

  cyc_t        exp_q[$];
  bit          m_last_wb;
  logic [15:0] m_retired;
  bit          acc_wb, acc_dbg;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle of the reference model, evaluated with inputs stable.
  task automatic model_step();
    cyc_t cur;
    bit   idle, exp_ready, exp_gnt, ne, nm;
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '{we: 1'b0, addr: 4'hF, data: 64'h0, done: 1'b0, busy: 1'b0};
    if (cur.done) m_retired = m_retired + 16'd1;
    chk("busy", busy_o, cur.busy);
    chk("we", rf_we_o, cur.we);
    chk("waddr", rf_waddr_o, cur.addr);
    if (cur.we) chk("wdata", rf_wdata_o, cur.data);
    chk("done", done_o, cur.done);
    chk("retired", retired_o, m_retired);

    idle      = !cur.busy;
    exp_ready = idle && !(dbg_req_i && m_last_wb);
    exp_gnt   = idle && dbg_req_i && !(wb_valid_i && !m_last_wb);
    chk("wb_ready", wb_ready_o, exp_ready);
    chk("dbg_gnt", dbg_gnt_o, exp_gnt);
    acc_wb  = exp_ready && wb_valid_i;
    acc_dbg = exp_gnt;

    if (acc_wb) begin
      m_last_wb = 1'b1;
      nm = (dstM_i != 4'hF);
      ne = (dstE_i != 4'hF) && (icode_i != 4'h2 || cnd_i) && !(nm && dstE_i == dstM_i);
      if (ne) exp_q.push_back('{we: 1'b1, addr: dstE_i, data: valE_i, done: !nm, busy: 1'b1});
      if (nm) exp_q.push_back('{we: 1'b1, addr: dstM_i, data: valM_i, done: 1'b1, busy: 1'b1});
      if (!ne && !nm) exp_q.push_back('{we: 1'b0, addr: 4'hF, data: 64'h0, done: 1'b1, busy: 1'b0});
    end else if (acc_dbg) begin
      m_last_wb = 1'b0;
      exp_q.push_back('{we: (dbg_addr_i != 4'hF), addr: dbg_addr_i, data: dbg_data_i,
                        done: 1'b0, busy: 1'b1});
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
    if (acc_wb)  wb_valid_i = 1'b0;
    if (acc_dbg) dbg_req_i  = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_wb(input logic [3:0] ic, input logic c, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    icode_i = ic; cnd_i = c; dstE_i = de; dstM_i = dm; valE_i = ve; valM_i = vm;
    wb_valid_i = 1'b1;
  endtask

  task automatic send_wb(input logic [3:0] ic, input logic c, input logic [3:0] de,
                         input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    int n;
    load_wb(ic, c, de, dm, ve, vm);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_wb && n < 20);
    if (!acc_wb) begin
      chk("wb_accept_timeout", {63'h0, acc_wb}, 64'h1);
      wb_valid_i = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n_i    = 1'b0;
    wb_valid_i = 1'b0;
    dbg_req_i  = 1'b0;
    exp_q.delete();
    m_last_wb  = 1'b0;
    m_retired  = 16'd0;
    acc_wb     = 1'b0;
    acc_dbg    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_we", rf_we_o, 1'b0);
    chk("rst_waddr", rf_waddr_o, 4'hF);
    chk("rst_wdata", rf_wdata_o, 64'h0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_retired", retired_o, 16'h0);
    chk("rst_busy", busy_o, 1'b0);
    rst_n_i = 1'b1;
  endtask

  initial begin
    icode_i = 4'h0; cnd_i = 1'b0; dstE_i = 4'hF; dstM_i = 4'hF;
    valE_i = '0; valM_i = '0; dbg_addr_i = 4'hF; dbg_data_i = '0;
    apply_reset();

    // addq, popq %rbx, popq %rsp, cmov not-taken / taken
    send_wb(4'h6, 1'b0, 4'h3, 4'hF, 64'h10, 64'h0);   idle_ticks(2);
    send_wb(4'hB, 1'b0, 4'h4, 4'h3, 64'h108, 64'hAB); idle_ticks(3);
    send_wb(4'hB, 1'b0, 4'h4, 4'h4, 64'h108, 64'h55); idle_ticks(2);
    send_wb(4'h2, 1'b0, 4'h1, 4'hF, 64'h7, 64'h0);    idle_ticks(2);
    send_wb(4'h2, 1'b1, 4'h1, 4'hF, 64'h7, 64'h0);    idle_ticks(2);

    // Both requesters held: grants must alternate starting with writeback.
    apply_reset();
    dbg_addr_i = 4'hF; dbg_data_i = 64'h99; dbg_req_i = 1'b1;
    load_wb(4'h6, 1'b0, 4'h2, 4'hF, 64'h21, 64'h0);
    for (int i = 0; i < 10; i++) begin
      if (!wb_valid_i) load_wb(4'h6, 1'b0, 4'h2, 4'hF, 64'h21 + i, 64'h0);
      if (!dbg_req_i) begin
        dbg_addr_i = (i % 2 == 0) ? 4'h5 : 4'hF;
        dbg_data_i = 64'h99 + i;
        dbg_req_i  = 1'b1;
      end
      tick();
    end
    wb_valid_i = 1'b0; dbg_req_i = 1'b0;
    idle_ticks(3);

    // Reset while the E half of a popq is on the port.
    send_wb(4'hB, 1'b0, 4'h4, 4'h3, 64'h108, 64'hAB);
    rst_n_i = 1'b0;
    #1;
    chk("midrst_we", rf_we_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_retired", retired_o, 16'h0);
    apply_reset();
    idle_ticks(3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (!wb_valid_i && ($urandom_range(0, 2) == 0)) begin
        logic [3:0] ic, de, dm;
        case ($urandom_range(0, 3))
          0: ic = 4'h2;
          1: ic = 4'h6;
          2: ic = 4'hB;
          default: ic = 4'($urandom);
        endcase
        de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        dm = ($urandom_range(0, 2) == 0) ? de : (($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom));
        load_wb(ic, 1'($urandom), de, dm, {$urandom, $urandom}, {$urandom, $urandom});
      end
      if (!dbg_req_i && ($urandom_range(0, 4) == 0)) begin
        dbg_addr_i = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        dbg_data_i = {$urandom, $urandom};
        dbg_req_i  = 1'b1;
      end
      tick();
    end
    wb_valid_i = 1'b0; dbg_req_i = 1'b0;
    idle_ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
